packet_injector: RTL and testbench

PACKET_INJECTOR -- requirements
Module: packet_injector

---
 rtl/packet_injector_pkg.sv | 37 +++
 rtl/packet_injector_desc_fifo.sv | 56 +++++
 rtl/packet_injector.sv | 186 ++++++++++++++++++
 tb/tb_packet_injector.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/packet_injector_pkg.sv
// -----------------------------------------------------------------------------
// packet_injector_pkg
// Shared definitions for the packet injector:
//   - state_t        : packet FSM state encoding (IDLE / HEAD / BODY)
//   - PKT_COUNT_W    : width of the transferred-header counter
//   - hdr_*_lsb()    : bit offsets of the header fields (dest, source, length)
//   - desc_w()       : packed descriptor width {vc, len, dest}
// -----------------------------------------------------------------------------
package packet_injector_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HEAD = 2'd1,
    ST_BODY = 2'd2
  } state_t;

  localparam int PKT_COUNT_W = 16;

  // Header layout, LSB first: dest, then source (my_addr), then body length.
  function automatic int hdr_dest_lsb(input int place);
    return place;
  endfunction

  function automatic int hdr_src_lsb(input int place, input int addr_w);
    return place + addr_w;
  endfunction

  function automatic int hdr_len_lsb(input int place, input int addr_w);
    return place + 2 * addr_w;
  endfunction

  // Descriptor packing inside the FIFO: {vc, len, dest}.
  function automatic int desc_w(input int addr_w, input int len_w, input int vc_w);
    return addr_w + len_w + vc_w;
  endfunction

endpackage

// File: rtl/packet_injector_desc_fifo.sv
// -----------------------------------------------------------------------------
// desc_fifo
// Synchronous descriptor FIFO, DEPTH entries (power of two, >= 2).
// Ports:
//   clk, reset      : clock, synchronous active-high reset (empties the FIFO)
//   i_push, i_data  : write request and data; ignored while full
//   i_pop           : read request; ignored while empty
//   o_data          : entry at the head of the FIFO (valid while !o_empty)
//   o_full, o_empty : occupancy flags
// -----------------------------------------------------------------------------
module desc_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_data    = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_do_pop)  r_rptr <= r_rptr + PTR_ONE;
    end
  end

  // Storage is data only; stale entries are unreachable once pointers reset.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/packet_injector.sv
// -----------------------------------------------------------------------------
// packet_injector
// Turns queued packet descriptors plus a payload stream into router phits:
// one header phit {len, my_addr, dest} followed by len body phits taken from
// the payload stream.
// Ports:
//   clk, reset                        : clock, synchronous active-high reset
//   my_addr                           : source address placed in every header
//   desc_valid/desc_ready             : descriptor handshake
//   desc_dest/desc_len/desc_vc        : destination, body phit count, VC
//   pay_data/pay_valid/pay_ready      : body payload stream
//   outdata/outsent_req/outnew        : phit, phit valid, head-of-packet marker
//   outvc_no                          : VC of the packet in flight
//   inready                           : router inport ready
//   busy                              : packet in flight or descriptor queued
//   pkt_count                         : transferred headers (wrapping)
// Build option:
//   PACKET_INJECTOR_STATS_EN defined  -> pkt_count counter present
//   undefined (default)               -> pkt_count tied to 0
// -----------------------------------------------------------------------------
module packet_injector
  import packet_injector_pkg::*;
#(
  parameter int phit_size               = 32,
  parameter int addr_length             = 4,
  parameter int addr_place_in_header    = 0,
  parameter int floorplusone_log2_no_vc = 2,
  parameter int len_width               = 4,
  parameter int desc_depth              = 2
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [addr_length-1:0]             my_addr,
  input  logic                               desc_valid,
  output logic                               desc_ready,
  input  logic [addr_length-1:0]             desc_dest,
  input  logic [len_width-1:0]               desc_len,
  input  logic [floorplusone_log2_no_vc-1:0] desc_vc,
  input  logic [phit_size-1:0]               pay_data,
  input  logic                               pay_valid,
  output logic                               pay_ready,
  output logic [phit_size-1:0]               outdata,
  output logic                               outsent_req,
  output logic                               outnew,
  output logic [floorplusone_log2_no_vc-1:0] outvc_no,
  input  logic                               inready,
  output logic                               busy,
  output logic [PKT_COUNT_W-1:0]             pkt_count
);

  localparam int VW       = floorplusone_log2_no_vc;
  localparam int DW       = desc_w(addr_length, len_width, VW);
  localparam int DEST_LSB = hdr_dest_lsb(addr_place_in_header);
  localparam int SRC_LSB  = hdr_src_lsb(addr_place_in_header, addr_length);
  localparam int LEN_LSB  = hdr_len_lsb(addr_place_in_header, addr_length);
  localparam logic [len_width-1:0] LEN_ONE = len_width'(1);

  state_t                 r_state;
  logic [len_width-1:0]   r_remaining;
  logic [phit_size-1:0]   r_hdr;
  logic [VW-1:0]          r_vc;

  logic [DW-1:0]          w_fifo_wdata;
  logic [DW-1:0]          w_fifo_rdata;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_pop;
  logic                   w_hdr_xfer;
  logic                   w_body_xfer;
  logic                   w_pkt_end;
  logic [addr_length-1:0] w_pop_dest;
  logic [len_width-1:0]   w_pop_len;
  logic [VW-1:0]          w_pop_vc;
  logic [phit_size-1:0]   w_pop_hdr;

  assign w_fifo_wdata = {desc_vc, desc_len, desc_dest};
  assign w_pop_dest   = w_fifo_rdata[0 +: addr_length];
  assign w_pop_len    = w_fifo_rdata[addr_length +: len_width];
  assign w_pop_vc     = w_fifo_rdata[addr_length + len_width +: VW];

  desc_fifo #(
    .WIDTH (DW),
    .DEPTH (desc_depth)
  ) u_desc_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (desc_valid),
    .i_data  (w_fifo_wdata),
    .i_pop   (w_pop),
    .o_data  (w_fifo_rdata),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign desc_ready = !w_full;
  assign busy       = (r_state != ST_IDLE) || !w_empty;

  // Header is built from the FIFO head at pop time so it stays stable while
  // the router stalls.
  always_comb begin
    w_pop_hdr                                = '0;
    w_pop_hdr[DEST_LSB +: addr_length]       = w_pop_dest;
    w_pop_hdr[SRC_LSB +: addr_length]        = my_addr;
    w_pop_hdr[LEN_LSB +: len_width]          = w_pop_len;
  end

  assign w_hdr_xfer  = (r_state == ST_HEAD) && inready;
  assign w_body_xfer = (r_state == ST_BODY) && pay_valid && inready;
  // Last phit of the current packet leaves this cycle.
  assign w_pkt_end   = (w_hdr_xfer && (r_remaining == '0)) ||
                       (w_body_xfer && (r_remaining == LEN_ONE));
  // Pop from IDLE, or at packet end so the next header follows with no gap.
  assign w_pop       = !w_empty && ((r_state == ST_IDLE) || w_pkt_end);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_remaining <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pop) r_state <= ST_HEAD;
        end
        ST_HEAD: begin
          if (w_hdr_xfer) begin
            if (r_remaining != '0) r_state <= ST_BODY;
            else                   r_state <= w_empty ? ST_IDLE : ST_HEAD;
          end
        end
        ST_BODY: begin
          if (w_body_xfer) begin
            r_remaining <= r_remaining - LEN_ONE;
            if (r_remaining == LEN_ONE) r_state <= w_empty ? ST_IDLE : ST_HEAD;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
      // A pop loads the next packet's length; overrides the final decrement.
      if (w_pop) r_remaining <= w_pop_len;
    end
  end

  always_ff @(posedge clk) begin
    if (w_pop) begin
      r_hdr <= w_pop_hdr;
      r_vc  <= w_pop_vc;
    end
  end

  always_comb begin
    outsent_req = 1'b0;
    outnew      = 1'b0;
    outdata     = '0;
    outvc_no    = '0;
    pay_ready   = 1'b0;
    case (r_state)
      ST_HEAD: begin
        outsent_req = 1'b1;
        outnew      = 1'b1;
        outdata     = r_hdr;
        outvc_no    = r_vc;
      end
      ST_BODY: begin
        outsent_req = pay_valid;
        outdata     = pay_data;
        outvc_no    = r_vc;
        pay_ready   = inready;
      end
      default: ;
    endcase
  end

`ifdef PACKET_INJECTOR_STATS_EN
  logic [PKT_COUNT_W-1:0] r_pkt_count;

  always_ff @(posedge clk) begin
    if (reset)           r_pkt_count <= '0;
    else if (w_hdr_xfer) r_pkt_count <= r_pkt_count + PKT_COUNT_W'(1);
  end

  assign pkt_count = r_pkt_count;
`else
  assign pkt_count = '0;
`endif

endmodule

// File: tb/tb_packet_injector.sv
module tb_packet_injector;

  localparam int PW    = 32;
  localparam int AW    = 4;
  localparam int PLACE = 0;
  localparam int VW    = 2;
  localparam int LW    = 4;
  localparam int DD    = 2;
`ifdef PACKET_INJECTOR_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] my_addr = '0;
  logic          desc_valid = 1'b0;
  logic          desc_ready;
  logic [AW-1:0] desc_dest = '0;
  logic [LW-1:0] desc_len = '0;
  logic [VW-1:0] desc_vc = '0;
  logic [PW-1:0] pay_data = '0;
  logic          pay_valid = 1'b0;
  logic          pay_ready;
  logic [PW-1:0] outdata;
  logic          outsent_req;
  logic          outnew;
  logic [VW-1:0] outvc_no;
  logic          inready = 1'b0;
  logic          busy;
  logic [15:0]   pkt_count;

  always #5 clk = ~clk;

  packet_injector #(
    .phit_size               (PW),
    .addr_length             (AW),
    .addr_place_in_header    (PLACE),
    .floorplusone_log2_no_vc (VW),
    .len_width               (LW),
    .desc_depth              (DD)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .my_addr     (my_addr),
    .desc_valid  (desc_valid),
    .desc_ready  (desc_ready),
    .desc_dest   (desc_dest),
    .desc_len    (desc_len),
    .desc_vc     (desc_vc),
    .pay_data    (pay_data),
    .pay_valid   (pay_valid),
    .pay_ready   (pay_ready),
    .outdata     (outdata),
    .outsent_req (outsent_req),
    .outnew      (outnew),
    .outvc_no    (outvc_no),
    .inready     (inready),
    .busy        (busy),
    .pkt_count   (pkt_count)
  );

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_cnt = '0;

  typedef struct {
    logic [PW-1:0] data;
    logic          nw;
    logic [VW-1:0] vc;
  } phit_t;

  phit_t exp_q[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [PW-1:0] mk_hdr(input logic [AW-1:0] dest,
                                           input logic [AW-1:0] src,
                                           input logic [LW-1:0] len);
    logic [PW-1:0] h;
    h = (PW'(dest) << PLACE) | (PW'(src) << (PLACE + AW)) | (PW'(len) << (PLACE + 2 * AW));
    return h;
  endfunction

  function automatic logic [PW-1:0] pay_word(input int i);
    return (PW'(i) * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  function automatic logic [15:0] cnt_exp();
    return STATS ? exp_cnt : 16'h0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    desc_valid = 1'b0;
    pay_valid  = 1'b0;
    inready    = 1'b0;
    step();
    step();
    reset   = 1'b0;
    exp_cnt = '0;
  endtask

  task automatic set_desc(input logic [AW-1:0] d, input logic [LW-1:0] l, input logic [VW-1:0] v);
    desc_valid = 1'b1;
    desc_dest  = d;
    desc_len   = l;
    desc_vc    = v;
  endtask

  // Randomized traffic checked against an ordered stream of expected phits.
  task automatic run_random(input int ncyc);
    int    cyc;
    int    pidx;
    int    eidx;
    bit    done;
    bit    dt;
    bit    pt;
    phit_t e;
    cyc  = 0;
    pidx = 0;
    eidx = 0;
    done = 0;
    exp_q.delete();
    pay_data = pay_word(0);
    while (!done) begin
      @(negedge clk);
      if (outsent_req && inready) begin
        check_eq("q_has_phit", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check_eq("rnd_data", 64'(outdata), 64'(e.data));
          check_eq("rnd_new", 64'(outnew), 64'(e.nw));
          check_eq("rnd_vc", 64'(outvc_no), 64'(e.vc));
          if (e.nw) exp_cnt++;
        end
      end
      dt = desc_valid && desc_ready;
      pt = pay_valid && pay_ready;
      if (dt) begin
        exp_q.push_back('{data: mk_hdr(desc_dest, my_addr, desc_len), nw: 1'b1, vc: desc_vc});
        for (int k = 0; k < int'(desc_len); k++) begin
          exp_q.push_back('{data: pay_word(eidx), nw: 1'b0, vc: desc_vc});
          eidx++;
        end
      end
      step();
      if (pt) pidx++;
      cyc++;
      if (cyc < ncyc) begin
        desc_valid = ($urandom_range(0, 2) == 0);
        desc_dest  = AW'($urandom);
        desc_len   = LW'($urandom_range(0, 4));
        desc_vc    = VW'($urandom);
        pay_valid  = ($urandom_range(0, 3) != 0);
        inready    = ($urandom_range(0, 3) != 0);
      end else begin
        desc_valid = 1'b0;
        pay_valid  = 1'b1;
        inready    = 1'b1;
      end
      pay_data = pay_word(pidx);
      if (cyc >= ncyc && !busy && exp_q.size() == 0) done = 1;
      if (cyc >= ncyc + 500) begin
        check_eq("drain_timeout", 64'(exp_q.size()) + 64'(busy), 64'd0);
        done = 1;
      end
    end
    check_eq("rnd_busy_end", 64'(busy), 64'd0);
    check_eq("rnd_q_empty", 64'(exp_q.size()), 64'd0);
    check_eq("rnd_pay_used", 64'(pidx), 64'(eidx));
    check_eq("rnd_pkt_count", 64'(pkt_count), 64'(cnt_exp()));
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    do_reset();
    check_eq("rst_desc_ready", 64'(desc_ready), 64'd1);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_outsent", 64'(outsent_req), 64'd0);
    check_eq("rst_outnew", 64'(outnew), 64'd0);
    check_eq("rst_outdata", 64'(outdata), 64'd0);
    check_eq("rst_pay_ready", 64'(pay_ready), 64'd0);
    check_eq("rst_vc", 64'(outvc_no), 64'd0);
    check_eq("rst_pkt_count", 64'(pkt_count), 64'd0);

    // Single packet: dest=5 my_addr=3 len=2 vc=1
    my_addr = 4'd3;
    inready = 1'b1;
    set_desc(4'd5, 4'd2, 2'd1);
    step();                                   // edge N: accepted
    desc_valid = 1'b0;
    check_eq("p1_idle_no_phit", 64'(outsent_req), 64'd0);
    check_eq("p1_busy_queued", 64'(busy), 64'd1);
    step();                                   // edge N+1: popped
    check_eq("p1_hdr_req", 64'(outsent_req), 64'd1);
    check_eq("p1_hdr_new", 64'(outnew), 64'd1);
    check_eq("p1_hdr_data", 64'(outdata), 64'h235);
    check_eq("p1_hdr_vc", 64'(outvc_no), 64'd1);
    check_eq("p1_hdr_pay_ready", 64'(pay_ready), 64'd0);
    pay_valid = 1'b1;
    pay_data  = 32'hA5A5_0001;
    step();                                   // edge N+2: header
    check_eq("p1_b0_data", 64'(outdata), 64'hA5A50001);
    check_eq("p1_b0_new", 64'(outnew), 64'd0);
    check_eq("p1_b0_pay_ready", 64'(pay_ready), 64'd1);
    check_eq("p1_b0_vc", 64'(outvc_no), 64'd1);
    pay_data = 32'hA5A5_0002;
    step();                                   // edge N+3: body 0
    check_eq("p1_b1_data", 64'(outdata), 64'hA5A50002);
    check_eq("p1_b1_req", 64'(outsent_req), 64'd1);
    step();                                   // edge N+4: body 1
    exp_cnt++;
    check_eq("p1_done_busy", 64'(busy), 64'd0);
    check_eq("p1_done_req", 64'(outsent_req), 64'd0);
    check_eq("p1_pkt_count", 64'(pkt_count), 64'(cnt_exp()));

    // len=0 packet, router stalls 3 cycles on the header
    set_desc(4'd9, 4'd0, 2'd2);
    inready = 1'b0;
    step();
    desc_valid = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      check_eq("stall_req", 64'(outsent_req), 64'd1);
      check_eq("stall_hdr", 64'(outdata), 64'h39);
      check_eq("stall_pay_ready", 64'(pay_ready), 64'd0);
      step();
    end
    inready = 1'b1;
    check_eq("stall_rel_hdr", 64'(outdata), 64'h39);
    check_eq("stall_rel_pay_ready", 64'(pay_ready), 64'd0);
    step();
    exp_cnt++;
    check_eq("len0_single_phit", 64'(outsent_req), 64'd0);
    check_eq("len0_pay_ready", 64'(pay_ready), 64'd0);
    check_eq("len0_pkt_count", 64'(pkt_count), 64'(cnt_exp()));

    // Back-to-back len=1 packets, FIFO full blocks a further descriptor
    inready   = 1'b0;
    pay_valid = 1'b1;
    set_desc(4'd1, 4'd1, 2'd0);
    step();
    set_desc(4'd2, 4'd1, 2'd1);
    step();
    set_desc(4'd3, 4'd1, 2'd2);
    step();
    set_desc(4'd4, 4'd2, 2'd3);
    check_eq("full_blocks_0", 64'(desc_ready), 64'd0);
    step();
    check_eq("full_blocks_1", 64'(desc_ready), 64'd0);
    check_eq("full_hdrA_held", 64'(outdata), 64'(mk_hdr(4'd1, 4'd3, 4'd1)));
    desc_valid = 1'b0;
    inready    = 1'b1;
    pay_data   = 32'h0000_BEEF;
    step();
    check_eq("b2b_A_body", 64'(outdata), 64'hBEEF);
    check_eq("b2b_A_body_new", 64'(outnew), 64'd0);
    step();
    check_eq("b2b_B_hdr_req", 64'(outsent_req), 64'd1);
    check_eq("b2b_B_hdr_new", 64'(outnew), 64'd1);
    check_eq("b2b_B_hdr", 64'(outdata), 64'(mk_hdr(4'd2, 4'd3, 4'd1)));
    check_eq("b2b_B_vc", 64'(outvc_no), 64'd1);
    check_eq("b2b_ready_again", 64'(desc_ready), 64'd1);
    step();
    step();
    check_eq("b2b_C_hdr", 64'(outdata), 64'(mk_hdr(4'd3, 4'd3, 4'd1)));
    check_eq("b2b_C_vc", 64'(outvc_no), 64'd2);
    step();
    step();
    exp_cnt = exp_cnt + 16'd3;
    check_eq("b2b_done_busy", 64'(busy), 64'd0);
    check_eq("b2b_done_req", 64'(outsent_req), 64'd0);
    check_eq("b2b_pkt_count", 64'(pkt_count), 64'(cnt_exp()));

    // Reset while in BODY with a further descriptor queued
    set_desc(4'd6, 4'd5, 2'd1);
    step();
    set_desc(4'd7, 4'd0, 2'd0);
    step();
    desc_valid = 1'b0;
    step();
    step();
    check_eq("mid_body_req", 64'(outsent_req), 64'd1);
    check_eq("mid_body_new", 64'(outnew), 64'd0);
    reset = 1'b1;
    step();
    check_eq("rstmid_req", 64'(outsent_req), 64'd0);
    check_eq("rstmid_busy", 64'(busy), 64'd0);
    check_eq("rstmid_desc_ready", 64'(desc_ready), 64'd1);
    check_eq("rstmid_pkt_count", 64'(pkt_count), 64'd0);
    check_eq("rstmid_pay_ready", 64'(pay_ready), 64'd0);
    reset   = 1'b0;
    exp_cnt = '0;
    step();
    step();
    check_eq("rstmid_discard_busy", 64'(busy), 64'd0);
    check_eq("rstmid_discard_req", 64'(outsent_req), 64'd0);

    // Randomized traffic against the stream model
    do_reset();
    my_addr = AW'($urandom);
    run_random(3000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
